// File: rtl/comp_seq_ctrl.sv
// Sequencer for an N-bit magnitude compare on one shared external 2-bit comparator slice, MSB pair first.
// Define COMP_EARLY_EXIT_EN to finish on the first unequal pair; by default latency is fixed at WIDTH/2 compare cycles.
module comp_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int IDX_W = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g,
    output logic [1:0]       slice_a,
    output logic [1:0]       slice_b,
    input  logic             slice_l,
    input  logic             slice_e,
    input  logic             slice_g
);

    localparam int P = WIDTH / 2;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(P - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             busy_r;
    logic             done_r;
    logic             l_r;
    logic             e_r;
    logic             g_r;
    logic [1:0]       slice_a_s;
    logic [1:0]       slice_b_s;
`ifndef COMP_EARLY_EXIT_EN
    logic             decided_r;
    logic             dec_l_r;
    logic             dec_g_r;
`endif

    function automatic logic [1:0] pair_sel(input logic [WIDTH-1:0] v, input logic [IDX_W-1:0] i);
        pair_sel = v[2 * i +: 2];
    endfunction

    assign busy    = busy_r;
    assign done    = done_r;
    assign l       = l_r;
    assign e       = e_r;
    assign g       = g_r;
    assign slice_a = slice_a_s;
    assign slice_b = slice_b_s;

    // Present the current latched bit pair to the slice only while comparing.
    always_comb begin
        slice_a_s = 2'b00;
        slice_b_s = 2'b00;
        if (state_r == ST_COMPARE) begin
            slice_a_s = pair_sel(a_r, idx_r);
            slice_b_s = pair_sel(b_r, idx_r);
        end else begin
            slice_a_s = 2'b00;
            slice_b_s = 2'b00;
        end
    end

    // Sequencer: accept, walk pairs MSB-first, resolve, then pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            idx_r     <= IDX_ZERO;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            l_r       <= 1'b0;
            e_r       <= 1'b0;
            g_r       <= 1'b0;
`ifndef COMP_EARLY_EXIT_EN
            decided_r <= 1'b0;
            dec_l_r   <= 1'b0;
            dec_g_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r       <= a;
                        b_r       <= b;
                        idx_r     <= IDX_TOP;
                        busy_r    <= 1'b1;
                        state_r   <= ST_COMPARE;
`ifndef COMP_EARLY_EXIT_EN
                        decided_r <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_COMPARE: begin
`ifdef COMP_EARLY_EXIT_EN
                    if (!slice_e) begin
                        l_r     <= slice_l;
                        g_r     <= slice_g;
                        e_r     <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else if (idx_r == IDX_ZERO) begin
                        l_r     <= 1'b0;
                        g_r     <= 1'b0;
                        e_r     <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r <= idx_r - 1'b1;
                    end
`else
                    // Later pairs are still walked but cannot override the first decision.
                    if (idx_r == IDX_ZERO) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_DONE;
                        if (decided_r) begin
                            l_r <= dec_l_r;
                            g_r <= dec_g_r;
                            e_r <= 1'b0;
                        end else if (!slice_e) begin
                            l_r <= slice_l;
                            g_r <= slice_g;
                            e_r <= 1'b0;
                        end else begin
                            l_r <= 1'b0;
                            g_r <= 1'b0;
                            e_r <= 1'b1;
                        end
                    end else begin
                        idx_r <= idx_r - 1'b1;
                        if (!decided_r && !slice_e) begin
                            decided_r <= 1'b1;
                            dec_l_r   <= slice_l;
                            dec_g_r   <= slice_g;
                        end else begin
                            decided_r <= decided_r;
                        end
                    end
`endif
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_seq_ctrl.sv
// Self-checking bench for comp_seq_ctrl: behavioural slice plus arithmetic reference model, directed and random compares.
module tb_comp_seq_ctrl;

    localparam int W = 8;
    localparam int P = W / 2;

    logic         clk_s = 1'b0;
    logic         rst_n_s;
    logic         start_s;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic         busy_s;
    logic         done_s;
    logic         l_s;
    logic         e_s;
    logic         g_s;
    logic [1:0]   slice_a_s;
    logic [1:0]   slice_b_s;
    logic         slice_l_s;
    logic         slice_e_s;
    logic         slice_g_s;
    logic         inj_s;

    int errors = 0;
    int checks = 0;
    int fault_cnt = 0;

    comp_seq_ctrl #(.WIDTH(W)) dut (
        .clk     (clk_s),
        .rst_n   (rst_n_s),
        .start   (start_s),
        .a       (a_s),
        .b       (b_s),
        .busy    (busy_s),
        .done    (done_s),
        .l       (l_s),
        .e       (e_s),
        .g       (g_s),
        .slice_a (slice_a_s),
        .slice_b (slice_b_s),
        .slice_l (slice_l_s),
        .slice_e (slice_e_s),
        .slice_g (slice_g_s)
    );

    always #5 clk_s = ~clk_s;

    // Behavioural 2-bit comparator slice, with an optional malformed response.
    always_comb begin
        if (inj_s) begin
            slice_l_s = 1'b1;
            slice_e_s = 1'b0;
            slice_g_s = 1'b1;
        end else begin
            slice_l_s = (slice_a_s < slice_b_s);
            slice_e_s = (slice_a_s == slice_b_s);
            slice_g_s = (slice_a_s > slice_b_s);
        end
    end

    // Flag malformed slice responses seen by the DUT.
    always @(negedge clk_s) begin
        if (busy_s && !slice_e_s && (slice_l_s == slice_g_s)) begin
            fault_cnt <= fault_cnt + 1;
            $display("slice fault flagged: a=%b b=%b l=%b g=%b", slice_a_s, slice_b_s, slice_l_s, slice_g_s);
        end
    end

    task automatic step();
        @(posedge clk_s);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude result by plain arithmetic; cycles from start edge to done.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic el, output logic ee, output logic eg, output int lat);
        int k;
        el = (x < y);
        ee = (x == y);
        eg = (x > y);
        k = 1;
`ifdef COMP_EARLY_EXIT_EN
        for (int i = P - 1; i > 0; i--) begin
            if (((x >> (2 * i)) & 8'd3) == ((y >> (2 * i)) & 8'd3)) k++;
            else break;
        end
`else
        k = P;
`endif
        lat = k + 1;
    endfunction

    task automatic run(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input bit spam, input bit inj);
        logic el, ee, eg;
        int lat;
        int pos;
        int done_cyc;
        int done_seen;
        model(ta, tb, el, ee, eg, lat);
        if (inj) begin
            el = 1'b1;
            ee = 1'b0;
            eg = 1'b1;
`ifdef COMP_EARLY_EXIT_EN
            lat = 2;
`endif
        end
        inj_s   = inj;
        a_s     = ta;
        b_s     = tb;
        start_s = 1'b1;
        step();
        if (!spam) start_s = 1'b0;
        check({tag, "_busy_start"}, 32'(busy_s), 32'd1);
        pos = P - 1;
        done_cyc = -1;
        done_seen = 0;
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            if (busy_s) begin
                check({tag, "_slice_pos_ok"}, 32'(pos >= 0), 32'd1);
                if (pos >= 0) begin
                    check({tag, "_slice_a"}, 32'(slice_a_s), 32'((ta >> (2 * pos)) & 8'd3));
                    check({tag, "_slice_b"}, 32'(slice_b_s), 32'((tb >> (2 * pos)) & 8'd3));
                end
                pos--;
            end
            step();
            if (spam) begin
                a_s = W'($urandom);
                b_s = W'($urandom);
            end
            if (done_s) begin
                done_cyc = cyc;
                done_seen++;
                start_s = 1'b0;
            end
        end
        inj_s = 1'b0;
        check({tag, "_latency"}, 32'(done_cyc), 32'(lat));
        check({tag, "_lge"}, {29'd0, l_s, e_s, g_s}, {29'd0, el, ee, eg});
        check({tag, "_busy_at_done"}, 32'(busy_s), 32'd0);
        step();
        check({tag, "_done_single"}, 32'(done_s), 32'd0);
        check({tag, "_hold_lge"}, {29'd0, l_s, e_s, g_s}, {29'd0, el, ee, eg});
        check({tag, "_idle_slice"}, {30'd0, slice_a_s}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int j;
        int f0;
        rst_n_s = 1'b0;
        start_s = 1'b0;
        inj_s   = 1'b0;
        a_s     = '0;
        b_s     = '0;
        repeat (3) step();
        check("rst_outs", {25'd0, busy_s, done_s, l_s, e_s, g_s, 2'd0}, 32'd0);
        check("rst_slice", {28'd0, slice_a_s, slice_b_s}, 32'd0);
        rst_n_s = 1'b1;
        step();
        check("post_rst_outs", {27'd0, busy_s, done_s, l_s, e_s, g_s}, 32'd0);

        run("gt_msb", 8'hC0, 8'h3F, 1'b0, 1'b0);
        run("lt_lsb", 8'hA5, 8'hA7, 1'b0, 1'b0);
        run("eq", 8'h5A, 8'h5A, 1'b0, 1'b0);
        run("spam", 8'hA5, 8'hA7, 1'b1, 1'b0);

        // Reset in the second compare cycle abandons the compare.
        a_s = 8'h00;
        b_s = 8'hFF;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        step();
        #2 rst_n_s = 1'b0;
        #1;
        check("midrst_outs", {27'd0, busy_s, done_s, l_s, e_s, g_s}, 32'd0);
        check("midrst_slice", {28'd0, slice_a_s, slice_b_s}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_no_done", 32'(done_s), 32'd0);
        end
        rst_n_s = 1'b1;
        step();
        check("midrst_idle_done", 32'(done_s), 32'd0);
        run("after_rst", 8'h00, 8'hFF, 1'b0, 1'b0);

        f0 = fault_cnt;
        run("slice_fault", 8'h12, 8'h34, 1'b0, 1'b1);
        check("slice_fault_flagged", 32'(fault_cnt > f0), 32'd1);

        for (int n = 0; n < 20; n++) begin
            ra = W'($urandom);
            rb = ra;
            j = int'($urandom_range(0, P));
            if (j < P) begin
                for (int i = 0; i <= j; i++) rb[2 * i +: 2] = 2'($urandom);
            end
            run("rand", ra, rb, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
